hazard_ctrl_p: RTL and testbench
================================

Name: hazard_ctrl_p

Overview:
- Parametrised hazard and stall controller for the 5-stage MIPS pipeline; successor to the current load-use/branch hazard logic.
- Detects load-use, branch/JR operand, and multi-cycle HI/LO hazards.
- Forwards branch/JR operands in ID, resolves BEQ/BNE in ID, and generates PC/IF-ID write enables and IF-ID/ID-EX flushes.
- Adds a multi-cycle mult/div busy tracker (FSM plus counter), register-0 suppression, per-source use flags, and a saturating stall-cycle performance counter.

Parameters:
- DW, 32, datapath width of operands and forwarded values.
- RW, 5, register-address width.
- MD_LAT, 32, cycles the mult/div unit stays busy after issue (>=2).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- npc_op  in  2  ID-stage next-PC select (package encodings).
- br_ne  in  1  branch in ID is BNE (0 = BEQ).
- id_rs, id_rt  in  RW  ID source registers.
- id_rs_use, id_rt_use  in  1  source is actually read by the ID instruction.
- id_md_use  in  1  ID instruction reads/writes HI/LO or starts mult/div.
- rd1, rd2  in  DW  register-file read data for rs/rt.
- idex_mem_r, idex_rf_wr  in  1  EX instruction is a load / writes the RF.
- idex_rd  in  RW  EX destination register.
- idex_md_start  in  1  EX instruction issues a mult/div.
- exmem_mem_r, exmem_rf_wr  in  1  MEM instruction is a load / writes the RF.
- exmem_rd  in  RW  MEM destination register.
- exmem_alu  in  DW  MEM ALU result.
- memwb_rf_wr  in  1  WB instruction writes the RF.
- memwb_rd  in  RW  WB destination register.
- wb_data  in  DW  WB write data.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- pc_wr  out  1  PC write enable.
- ifid_wr  out  1  IF/ID write enable.
- ifid_flush  out  1  squash IF/ID.
- idex_flush  out  1  insert bubble into ID/EX.
- br_taken  out  1  branch resolved taken.
- fwd_rd1, fwd_rd2  out  DW  forwarded branch/JR operands.
- md_busy  out  1  mult/div unit busy.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Source-match rule: a source matches a destination only if its use flag is 1, the register is nonzero, and the addresses are equal.
- load_use: idex_mem_r and idex_rd matches a source.
- ctl_haz (npc_op is BRANCH or JR; JR checks rs only):
  - idex_rf_wr and idex_rd matches; or
  - exmem_mem_r and exmem_rd matches.
- md_haz: id_md_use and (md_busy or idex_md_start).
- stall = load_use | ctl_haz | md_haz.
- On stall:
  - pc_wr = 0, ifid_wr = 0, idex_flush = 1.
  - ifid_flush = 0, br_taken = 0.
- Without stall:
  - pc_wr = 1, ifid_wr = 1, idex_flush = 0.
  - ifid_flush = 1 if npc_op is JUMP or JR, or br_taken.
- br_taken = (npc_op == BRANCH) and (fwd_rd1 == fwd_rd2) XOR br_ne, forced to 0 on stall.
- Forwarding, per operand:
  - First choice: exmem_alu, if exmem_rf_wr, not exmem_mem_r, and exmem_rd matches.
  - Otherwise: wb_data, if memwb_rf_wr and memwb_rd matches.
  - Otherwise: rd1/rd2.
  - MEM has priority over WB.
- All of the above is combinational from the inputs and the md state.
- MD FSM, states IDLE and BUSY, counter width clog2(MD_LAT):
  - IDLE with idex_md_start: go to BUSY, cnt = MD_LAT-1.
  - BUSY: cnt decrements each cycle; at cnt == 0 go to IDLE.
  - md_busy = 1 exactly in BUSY, i.e. MD_LAT cycles after the issue cycle.
  - idex_md_start while BUSY cannot occur: md_haz prevents it; such starts are ignored.
- stall_cnt:
  - Increments by 1 on each clock edge where stall = 1.
  - Saturates at all-ones.
  - cnt_clr has priority over increment.
- Reset: asynchronous; at any point, including mid-BUSY, state = IDLE, cnt = 0, stall_cnt = 0, md_busy = 0.
  - While rst = 1 the combinational outputs follow the rules above with md_busy = 0.
- Simultaneous conditions:
  - Stall always wins over flush.
  - With JUMP and load_use, the jump holds in ID and flushes one cycle later.

Decomposition:
- Shared package hazard_pkg: NPC_PLUS4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JR = 2'b11, plus the md_state_t enum (IDLE, BUSY).
- Sub-module md_busy_tracker: holds the FSM and counter, parametrised by MD_LAT.
- Hazard, forward and counter logic stay in the top block.

Test Plan:
- Load-use stall:
  - Stimulus: idex_mem_r = 1, idex_rd = 8, id_rs = 8, id_rs_use = 1, npc_op = PLUS4.
  - Required: pc_wr = 0, ifid_wr = 0, idex_flush = 1, stall_cnt +1.
  - Repeat with id_rs = 0 and idex_rd = 0: no stall.
- BEQ with MEM forward:
  - Stimulus: npc_op = BRANCH, id_rs = 3, id_rt = 4, rd1 = 5, rd2 = 9, exmem_rf_wr = 1, exmem_rd = 4, exmem_alu = 5.
  - Required: fwd_rd2 = 5, br_taken = 1, ifid_flush = 1.
  - With br_ne = 1: br_taken = 0.
- Forward priority:
  - Stimulus: exmem_rd = memwb_rd = 4, both RF writes, exmem_alu = 7, wb_data = 5.
  - Required: fwd_rd2 = 7.
- Branch after load in MEM:
  - Stimulus: exmem_mem_r = 1, exmem_rd = 3, npc_op = BRANCH, id_rs = 3.
  - Required: stall, br_taken = 0, ifid_flush = 0.
- Mult/div busy (MD_LAT = 4):
  - Stimulus: idex_md_start pulsed for 1 cycle; id_md_use = 1 held.
  - Required: stall for 5 cycles (issue cycle plus 4 BUSY), md_busy high exactly 4 cycles.
  - Assert rst mid-BUSY: md_busy drops immediately.
- JR and counter:
  - Stimulus: npc_op = JR, no hazard.
  - Required: ifid_flush = 1, pc_wr = 1.
  - Force the stall counter to saturate with CNT_W = 4: it holds at 15; cnt_clr then gives 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/stall controller: next-PC select codes and
// the mult/div tracker state type.
package hazard_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the multi-cycle mult/div unit: busy for exactly MD_LAT cycles after
// the cycle in which a mult/div issues from EX.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  output logic md_busy
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  md_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (md_start) begin
          state_nxt = BUSY;
          cnt_nxt   = CW'(MD_LAT - 1);
        end
      end
      BUSY: begin
        // A start while busy cannot legally occur and is ignored here.
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    md_busy = (state == BUSY);
  end

endmodule

// File: rtl/hazard_ctrl_p.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use,
// branch/JR operand and HI/LO hazards, ID-stage branch resolution/forwarding.
module hazard_ctrl_p
  import hazard_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       npc_op,
  input  logic             br_ne,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic             id_rs_use,
  input  logic             id_rt_use,
  input  logic             id_md_use,
  input  logic [DW-1:0]    rd1,
  input  logic [DW-1:0]    rd2,
  input  logic             idex_mem_r,
  input  logic             idex_rf_wr,
  input  logic [RW-1:0]    idex_rd,
  input  logic             idex_md_start,
  input  logic             exmem_mem_r,
  input  logic             exmem_rf_wr,
  input  logic [RW-1:0]    exmem_rd,
  input  logic [DW-1:0]    exmem_alu,
  input  logic             memwb_rf_wr,
  input  logic [RW-1:0]    memwb_rd,
  input  logic [DW-1:0]    wb_data,
  input  logic             cnt_clr,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             br_taken,
  output logic [DW-1:0]    fwd_rd1,
  output logic [DW-1:0]    fwd_rd2,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // $zero never carries a real dependency, and unread sources never match.
  function automatic logic src_match(input logic use_f, input logic [RW-1:0] src,
                                     input logic [RW-1:0] dst);
    return use_f && (src != '0) && (src == dst);
  endfunction

  logic is_br, is_jr;
  logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
  logic load_use, ctl_haz, md_haz, stall;

  md_busy_tracker #(.MD_LAT(MD_LAT)) u_md (
    .clk     (clk),
    .rst     (rst),
    .md_start(idex_md_start),
    .md_busy (md_busy)
  );

  always_comb begin
    is_br  = (npc_op == NPC_BRANCH);
    is_jr  = (npc_op == NPC_JR);
    rs_ex  = src_match(id_rs_use, id_rs, idex_rd);
    rt_ex  = src_match(id_rt_use, id_rt, idex_rd);
    rs_mem = src_match(id_rs_use, id_rs, exmem_rd);
    rt_mem = src_match(id_rt_use, id_rt, exmem_rd);
    rs_wb  = src_match(id_rs_use, id_rs, memwb_rd);
    rt_wb  = src_match(id_rt_use, id_rt, memwb_rd);

    load_use = idex_mem_r && (rs_ex || rt_ex);
    // Branches need both operands in ID; JR only reads rs.
    ctl_haz  = (is_br && ((idex_rf_wr && (rs_ex || rt_ex)) ||
                          (exmem_mem_r && (rs_mem || rt_mem)))) ||
               (is_jr && ((idex_rf_wr && rs_ex) || (exmem_mem_r && rs_mem)));
    md_haz   = id_md_use && (md_busy || idex_md_start);
    stall    = load_use || ctl_haz || md_haz;
  end

  // Operand forwarding into ID: a MEM ALU result is newer than WB data.
  always_comb begin
    fwd_rd1 = rd1;
    fwd_rd2 = rd2;
    if (exmem_rf_wr && !exmem_mem_r && rs_mem) fwd_rd1 = exmem_alu;
    else if (memwb_rf_wr && rs_wb)             fwd_rd1 = wb_data;
    if (exmem_rf_wr && !exmem_mem_r && rt_mem) fwd_rd2 = exmem_alu;
    else if (memwb_rf_wr && rt_wb)             fwd_rd2 = wb_data;
  end

  // A stall holds the ID instruction, so it must never also flush IF/ID.
  always_comb begin
    pc_wr      = !stall;
    ifid_wr    = !stall;
    idex_flush = stall;
    br_taken   = !stall && is_br && ((fwd_rd1 == fwd_rd2) ^ br_ne);
    ifid_flush = !stall && ((npc_op == NPC_JUMP) || is_jr || br_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           stall_cnt <= '0;
    else if (cnt_clr)                  stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Self-checking bench for hazard_ctrl_p: directed scenarios plus randomized
// traffic compared against a behavioural pipeline-hazard model.
module tb_hazard_ctrl_p;
  import hazard_pkg::*;

  localparam int DW     = 32;
  localparam int RW     = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       npc_op;
  logic             br_ne;
  logic [RW-1:0]    id_rs, id_rt;
  logic             id_rs_use, id_rt_use, id_md_use;
  logic [DW-1:0]    rd1, rd2;
  logic             idex_mem_r, idex_rf_wr, idex_md_start;
  logic [RW-1:0]    idex_rd;
  logic             exmem_mem_r, exmem_rf_wr;
  logic [RW-1:0]    exmem_rd;
  logic [DW-1:0]    exmem_alu;
  logic             memwb_rf_wr;
  logic [RW-1:0]    memwb_rd;
  logic [DW-1:0]    wb_data;
  logic             cnt_clr;
  logic             pc_wr, ifid_wr, ifid_flush, idex_flush, br_taken, md_busy;
  logic [DW-1:0]    fwd_rd1, fwd_rd2;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: cycles of mult/div busy left, and the stall tally.
  int md_left = 0;
  int cnt_m   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_p #(.DW(DW), .RW(RW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .npc_op(npc_op), .br_ne(br_ne),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .id_md_use(id_md_use), .rd1(rd1), .rd2(rd2),
    .idex_mem_r(idex_mem_r), .idex_rf_wr(idex_rf_wr), .idex_rd(idex_rd),
    .idex_md_start(idex_md_start),
    .exmem_mem_r(exmem_mem_r), .exmem_rf_wr(exmem_rf_wr), .exmem_rd(exmem_rd),
    .exmem_alu(exmem_alu), .memwb_rf_wr(memwb_rf_wr), .memwb_rd(memwb_rd),
    .wb_data(wb_data), .cnt_clr(cnt_clr),
    .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .br_taken(br_taken), .fwd_rd1(fwd_rd1),
    .fwd_rd2(fwd_rd2), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Does the ID instruction genuinely read register r?
  function automatic bit reads_reg(input logic [RW-1:0] r);
    if (r == 0) return 0;
    return (id_rs_use && id_rs == r) || (id_rt_use && id_rt == r);
  endfunction

  // Registers a branch/JR needs resolved in ID.
  function automatic bit ctl_reads(input logic [RW-1:0] r);
    if (npc_op == NPC_BRANCH) return reads_reg(r);
    if (npc_op == NPC_JR)     return (r != 0) && id_rs_use && (id_rs == r);
    return 0;
  endfunction

  // Newest in-flight value of a source register, else the register file.
  function automatic logic [DW-1:0] newest(input logic [RW-1:0] src, input bit used,
                                           input logic [DW-1:0] rf);
    if (!used || src == 0) return rf;
    if (exmem_rf_wr && !exmem_mem_r && exmem_rd == src) return exmem_alu;
    if (memwb_rf_wr && memwb_rd == src) return wb_data;
    return rf;
  endfunction

  task automatic check_all(output bit stall_e);
    bit busy_e, taken_e, flush_e;
    logic [DW-1:0] e1, e2;
    busy_e  = (md_left > 0);
    stall_e = (idex_mem_r && reads_reg(idex_rd)) ||
              (idex_rf_wr && ctl_reads(idex_rd)) ||
              (exmem_mem_r && ctl_reads(exmem_rd)) ||
              (id_md_use && (busy_e || idex_md_start));
    e1 = newest(id_rs, id_rs_use, rd1);
    e2 = newest(id_rt, id_rt_use, rd2);
    taken_e = !stall_e && (npc_op == NPC_BRANCH) && ((e1 == e2) != br_ne);
    flush_e = !stall_e && (npc_op == NPC_JUMP || npc_op == NPC_JR || taken_e);
    check("pc_wr",      pc_wr,      !stall_e);
    check("ifid_wr",    ifid_wr,    !stall_e);
    check("idex_flush", idex_flush, stall_e);
    check("br_taken",   br_taken,   taken_e);
    check("ifid_flush", ifid_flush, flush_e);
    check("fwd_rd1",    fwd_rd1,    e1);
    check("fwd_rd2",    fwd_rd2,    e2);
    check("md_busy",    md_busy,    busy_e);
    check("stall_cnt",  stall_cnt,  cnt_m);
  endtask

  // Inputs are set after a falling edge; check, then advance one clock.
  task automatic cycle();
    bit st;
    #1;
    check_all(st);
    @(posedge clk);
    if (!rst) begin
      if (cnt_clr)                  cnt_m = 0;
      else if (st && cnt_m < CNT_MAX) cnt_m++;
      if (md_left > 0)              md_left--;
      else if (idex_md_start)       md_left = MD_LAT;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    npc_op = NPC_PLUS4; br_ne = 0;
    id_rs = 0; id_rt = 0; id_rs_use = 0; id_rt_use = 0; id_md_use = 0;
    rd1 = 0; rd2 = 0;
    idex_mem_r = 0; idex_rf_wr = 0; idex_rd = 0; idex_md_start = 0;
    exmem_mem_r = 0; exmem_rf_wr = 0; exmem_rd = 0; exmem_alu = 0;
    memwb_rf_wr = 0; memwb_rd = 0; wb_data = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    md_left = 0;
    cnt_m = 0;
    #1;
  endtask

  int stalls, busies;

  initial begin
    quiet();
    do_reset();
    @(negedge clk);
    cycle();              // outputs follow the rules while rst is held
    rst = 1'b0;
    check("rst_cnt", stall_cnt, 0);
    check("rst_busy", md_busy, 0);
    cycle();

    // Load-use stall
    idex_mem_r = 1; idex_rd = 8; id_rs = 8; id_rs_use = 1;
    #1;
    check("lu_pc_wr", pc_wr, 0);
    check("lu_idex_flush", idex_flush, 1);
    cycle();
    check("lu_cnt_inc", stall_cnt, 1);
    id_rs = 0; idex_rd = 0;
    #1;
    check("lu_r0_pc_wr", pc_wr, 1);
    cycle();

    // BEQ with MEM forward, then as BNE
    quiet();
    npc_op = NPC_BRANCH; id_rs = 3; id_rt = 4; id_rs_use = 1; id_rt_use = 1;
    rd1 = 5; rd2 = 9; exmem_rf_wr = 1; exmem_rd = 4; exmem_alu = 5;
    #1;
    check("beq_fwd2", fwd_rd2, 5);
    check("beq_taken", br_taken, 1);
    check("beq_flush", ifid_flush, 1);
    cycle();
    br_ne = 1;
    #1;
    check("bne_taken", br_taken, 0);
    cycle();

    // MEM beats WB
    br_ne = 0; memwb_rf_wr = 1; memwb_rd = 4; exmem_alu = 7; wb_data = 5;
    #1;
    check("prio_fwd2", fwd_rd2, 7);
    cycle();

    // Branch after load in MEM
    quiet();
    exmem_mem_r = 1; exmem_rd = 3; npc_op = NPC_BRANCH; id_rs = 3; id_rs_use = 1;
    #1;
    check("brld_stall", pc_wr, 0);
    check("brld_taken", br_taken, 0);
    check("brld_flush", ifid_flush, 0);
    cycle();

    // Mult/div busy window
    quiet();
    id_md_use = 1; idex_md_start = 1;
    stalls = 0; busies = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!pc_wr) stalls++;
      if (md_busy) busies++;
      cycle();
      idex_md_start = 0;
    end
    check("md_stalls", stalls, 5);
    check("md_busy_cycles", busies, 4);

    // Reset in the middle of BUSY
    idex_md_start = 1;
    cycle();
    idex_md_start = 0;
    cycle();
    #2;
    do_reset();
    check("md_rst_busy", md_busy, 0);
    check("md_rst_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // JR with no hazard
    quiet();
    npc_op = NPC_JR; id_rs = 9; id_rs_use = 1;
    #1;
    check("jr_flush", ifid_flush, 1);
    check("jr_pc_wr", pc_wr, 1);
    cycle();

    // Saturate the stall counter, then clear
    quiet();
    idex_mem_r = 1; idex_rd = 2; id_rt = 2; id_rt_use = 1;
    for (int i = 0; i < CNT_MAX + 4; i++) cycle();
    check("sat_hold", stall_cnt, CNT_MAX);
    cnt_clr = 1;
    cycle();
    check("sat_clr", stall_cnt, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      npc_op = 2'($urandom_range(0, 3));
      br_ne  = 1'($urandom_range(0, 1));
      id_rs = RW'($urandom_range(0, 3)); id_rt = RW'($urandom_range(0, 3));
      id_rs_use = 1'($urandom_range(0, 1)); id_rt_use = 1'($urandom_range(0, 1));
      id_md_use = ($urandom_range(0, 3) == 0);
      rd1 = DW'($urandom_range(0, 2)); rd2 = DW'($urandom_range(0, 2));
      idex_mem_r = ($urandom_range(0, 4) == 0); idex_rf_wr = 1'($urandom_range(0, 1));
      idex_rd = RW'($urandom_range(0, 3));
      idex_md_start = (md_left == 0) && ($urandom_range(0, 5) == 0);
      exmem_mem_r = ($urandom_range(0, 4) == 0); exmem_rf_wr = 1'($urandom_range(0, 1));
      exmem_rd = RW'($urandom_range(0, 3)); exmem_alu = DW'($urandom_range(0, 2));
      memwb_rf_wr = 1'($urandom_range(0, 1)); memwb_rd = RW'($urandom_range(0, 3));
      wb_data = DW'($urandom_range(0, 2));
      cnt_clr = ($urandom_range(0, 30) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
